// File: rtl/count_engine_arbiter_if.sv
// Handshake bundle between two requesters, the count engine and the arbiter.
// The master modport is the requester/engine side and the slave modport is the arbiter side.
interface count_engine_arbiter_if;
  logic [1:0] req;
  logic       eng_ready;
  logic       eng_start;
  logic [1:0] gnt;
  logic [1:0] done;
  logic [1:0] err;
  logic       busy;

  modport master (
    output req, eng_ready,
    input  eng_start, gnt, done, err, busy
  );

  modport slave (
    input  req, eng_ready,
    output eng_start, gnt, done, err, busy
  );
endinterface

// File: rtl/count_engine_arbiter.sv
// Two-requester round-robin arbiter that owns a shared count engine.
// A watchdog aborts any transaction that waits on the engine for too long.
module count_engine_arbiter #(
  parameter int TIMEOUT  = 200,
  parameter int TO_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  count_engine_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GRANT     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RELEASE   = 3'd4
  } state_t;

  localparam logic [TO_WIDTH-1:0] WD_ONE  = TO_WIDTH'(1);
  localparam logic [TO_WIDTH-1:0] WD_LAST = TO_WIDTH'(TIMEOUT - 1);

  state_t              state_r;
  state_t              state_s;
  logic                owner_r;
  logic                owner_s;
  logic                to_r;
  logic                to_s;
  logic                last_served_r;
  logic [TO_WIDTH-1:0] wd_r;
  logic [TO_WIDTH-1:0] wd_inc_s;
  logic                timeout_s;

  function automatic logic [1:0] onehot2(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

  // The abort fires in the cycle whose increment would bring the watchdog to TIMEOUT-1.
  assign wd_inc_s  = wd_r + WD_ONE;
  assign timeout_s = (wd_inc_s == WD_LAST);

  // State, owner, timeout flag, fairness and watchdog registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      owner_r       <= 1'b0;
      to_r          <= 1'b0;
      last_served_r <= 1'b1;
      wd_r          <= '0;
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
      to_r    <= to_s;
      case (state_r)
        RELEASE:              last_served_r <= owner_r;
        default:              last_served_r <= last_served_r;
      endcase
      case (state_r)
        WAIT_BUSY, WAIT_DONE: wd_r <= wd_inc_s;
        default:              wd_r <= '0;
      endcase
    end
  end

  // Next-state, owner selection and abort flag
  always_comb begin
    state_s = state_r;
    owner_s = owner_r;
    to_s    = to_r;
    case (state_r)
      IDLE: begin
        if (bus.req != 2'b00) begin
          state_s = GRANT;
          to_s    = 1'b0;
          if (bus.req == 2'b11) begin
            owner_s = ~last_served_r;
          end else begin
            owner_s = bus.req[1];
          end
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: state_s = WAIT_BUSY;
      WAIT_BUSY: begin
        if (timeout_s) begin
          state_s = RELEASE;
          to_s    = 1'b1;
        end else if (!bus.eng_ready) begin
          state_s = WAIT_DONE;
        end else begin
          state_s = WAIT_BUSY;
        end
      end
      WAIT_DONE: begin
        if (timeout_s) begin
          state_s = RELEASE;
          to_s    = 1'b1;
        end else if (bus.eng_ready) begin
          state_s = RELEASE;
          to_s    = 1'b0;
        end else begin
          state_s = WAIT_DONE;
        end
      end
      RELEASE: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Moore outputs decoded from the state and owner registers only
  always_comb begin
    bus.eng_start = 1'b0;
    bus.gnt       = 2'b00;
    bus.done      = 2'b00;
    bus.err       = 2'b00;
    bus.busy      = 1'b1;
    case (state_r)
      IDLE: bus.busy = 1'b0;
      GRANT: begin
        bus.eng_start = 1'b1;
        bus.gnt       = onehot2(owner_r);
      end
      WAIT_BUSY, WAIT_DONE: bus.gnt = onehot2(owner_r);
      RELEASE: begin
        bus.gnt = onehot2(owner_r);
        if (to_r) begin
          bus.err = onehot2(owner_r);
        end else begin
          bus.done = onehot2(owner_r);
        end
      end
      default: bus.busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_count_engine_arbiter.sv
// Directed bench for count_engine_arbiter: single request, contention, timeout,
// request drop, asynchronous reset and the timeout/ready race.
module tb_count_engine_arbiter;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  count_engine_arbiter_if bus ();

  count_engine_arbiter #(.TIMEOUT(200), .TO_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full contended transaction; next_req is applied in RELEASE.
  task automatic run_txn(input string tag, input logic [1:0] exp_gnt, input logic [1:0] next_req);
    step();
    chk({tag, "_gnt"}, {6'd0, bus.gnt}, {6'd0, exp_gnt});
    chk({tag, "_start"}, {7'd0, bus.eng_start}, 8'h01);
    step();
    bus.eng_ready = 1'b0;
    step();
    bus.eng_ready = 1'b1;
    step();
    chk({tag, "_done"}, {6'd0, bus.done}, {6'd0, exp_gnt});
    bus.req = next_req;
    step();
    chk({tag, "_idle_gnt"}, {6'd0, bus.gnt}, 8'h00);
    chk({tag, "_idle_busy"}, {7'd0, bus.busy}, 8'h00);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.req = 2'b00;
    bus.eng_ready = 1'b1;
    #12;
    chk("rst_gnt", {6'd0, bus.gnt}, 8'h00);
    chk("rst_outs", {4'd0, bus.eng_start, bus.busy, bus.done[0] | bus.done[1], bus.err[0] | bus.err[1]}, 8'h00);
    step();
    rst = 1'b0;

    // Single request with a 10-cycle engine run
    bus.req = 2'b01;
    step();
    chk("single_start", {7'd0, bus.eng_start}, 8'h01);
    chk("single_gnt_grant", {6'd0, bus.gnt}, 8'h01);
    chk("single_busy", {7'd0, bus.busy}, 8'h01);
    bus.req = 2'b00;
    step();
    chk("single_start_once", {7'd0, bus.eng_start}, 8'h00);
    step();
    bus.eng_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("single_gnt_run", {bus.done, bus.err, 2'b00, bus.gnt}, 8'h01);
    end
    bus.eng_ready = 1'b1;
    step();
    chk("single_done", {4'd0, bus.done, bus.err}, 8'h04);
    chk("single_gnt_rel", {6'd0, bus.gnt}, 8'h01);
    step();
    chk("single_gnt_after", {6'd0, bus.gnt}, 8'h00);
    chk("single_done_after", {6'd0, bus.done}, 8'h00);

    // Contention after reset alternates starting with requester 0
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req = 2'b11;
    run_txn("cont1", 2'b01, 2'b11);
    run_txn("cont2", 2'b10, 2'b11);
    run_txn("cont3", 2'b01, 2'b11);
    run_txn("cont4", 2'b10, 2'b00);

    // Timeout: engine never leaves ready, WAIT_BUSY lasts 199 cycles
    bus.req = 2'b10;
    step();
    chk("to_gnt", {6'd0, bus.gnt}, 8'h02);
    bus.req = 2'b00;
    step();
    for (int i = 0; i < 198; i++) begin
      step();
      chk("to_wait", {bus.done, bus.err, 2'b00, bus.gnt}, 8'h02);
    end
    step();
    chk("to_err", {6'd0, bus.err}, 8'h02);
    chk("to_done", {6'd0, bus.done}, 8'h00);
    step();
    chk("to_idle_busy", {7'd0, bus.busy}, 8'h00);
    chk("to_idle_err", {6'd0, bus.err}, 8'h00);

    // Owner drops its request while the engine is running
    bus.req = 2'b01;
    step();
    step();
    bus.eng_ready = 1'b0;
    step();
    bus.req = 2'b00;
    step();
    chk("drop_gnt", {6'd0, bus.gnt}, 8'h01);
    chk("drop_busy", {7'd0, bus.busy}, 8'h01);
    bus.eng_ready = 1'b1;
    step();
    chk("drop_done", {4'd0, bus.done, bus.err}, 8'h04);
    step();

    // Asynchronous reset during WAIT_DONE
    bus.req = 2'b01;
    step();
    step();
    bus.eng_ready = 1'b0;
    step();
    chk("arst_pre_gnt", {6'd0, bus.gnt}, 8'h01);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_gnt", {6'd0, bus.gnt}, 8'h00);
    chk("arst_busy", {7'd0, bus.busy}, 8'h00);
    step();
    chk("arst_no_pulse", {4'd0, bus.done, bus.err}, 8'h00);
    rst = 1'b0;
    bus.eng_ready = 1'b1;
    bus.req = 2'b11;
    step();
    chk("arst_first_gnt", {6'd0, bus.gnt}, 8'h01);
    bus.req = 2'b00;
    step();
    bus.eng_ready = 1'b0;
    step();
    bus.eng_ready = 1'b1;
    step();
    chk("arst_txn_done", {6'd0, bus.done}, 8'h01);
    step();

    // Engine becomes ready in the very cycle the watchdog expires
    bus.req = 2'b01;
    step();
    bus.req = 2'b00;
    step();
    bus.eng_ready = 1'b0;
    step();
    for (int i = 0; i < 197; i++) begin
      step();
    end
    chk("race_still_wait", {bus.done, bus.err, 2'b00, bus.gnt}, 8'h01);
    bus.eng_ready = 1'b1;
    step();
    chk("race_err", {6'd0, bus.err}, 8'h01);
    chk("race_done", {6'd0, bus.done}, 8'h00);
    step();
    chk("race_idle", {7'd0, bus.busy}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/count_engine_arbiter.md
COUNT_ENGINE_ARBITER -- requirements
Module: count_engine_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 200, meaning: max cycles granted requester may wait for the count engine before abort.
REQ-002 Parameter TO_WIDTH, default 8, meaning: width of watchdog counter; TIMEOUT SHALL be at most 2^TO_WIDTH - 1.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  2  level request per requester; bit i = requester i.
REQ-006 eng_ready  input  1  count engine ready (1 = engine idle, 0 = running).
REQ-007 eng_start  output  1  start pulse to count engine.
REQ-008 gnt  output  2  one-hot grant, held for the whole transaction.
REQ-009 done  output  2  one-cycle pulse to requester i on normal completion.
REQ-010 err  output  2  one-cycle pulse to requester i on watchdog abort.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 FSM states SHALL be IDLE, GRANT, WAIT_BUSY, WAIT_DONE, RELEASE; all outputs SHALL be Moore (decoded from state and registered grant/owner), no combinational path from req to any output.
REQ-013 IDLE: no req -> stay; one req bit set -> GRANT for that requester; both set -> GRANT for the requester not served last (last_served register).
REQ-014 Owner SHALL be latched on IDLE->GRANT and held unchanged until leaving RELEASE; gnt = one-hot of owner in GRANT, WAIT_BUSY, WAIT_DONE, RELEASE; gnt = 0 in IDLE.
REQ-015 GRANT: eng_start = 1 for exactly one cycle; unconditional -> WAIT_BUSY.
REQ-016 WAIT_BUSY: eng_ready = 0 -> WAIT_DONE; else stay.
REQ-017 WAIT_DONE: eng_ready = 1 -> RELEASE with normal completion; else stay.
REQ-018 RELEASE: done[owner] = 1 (normal) or err[owner] = 1 (timeout) for one cycle; last_served <= owner; -> IDLE.
REQ-019 Watchdog counter SHALL clear on entry to GRANT, increment each cycle in WAIT_BUSY or WAIT_DONE, and on reaching TIMEOUT-1 force -> RELEASE with timeout flag set, overriding eng_ready in that cycle.
REQ-020 Request drop by owner after grant SHALL NOT abort the transaction; engine cannot be cancelled, sequence completes normally.
REQ-021 Non-owner req SHALL be ignored until IDLE; earliest next grant = cycle after RELEASE (IDLE sampled, GRANT on following edge).
REQ-022 Minimum transaction: GRANT, WAIT_BUSY, WAIT_DONE, RELEASE = 4 cycles + engine run time; req-to-eng_start latency = 1 cycle from IDLE.
REQ-023 done and err SHALL never be asserted in the same cycle; at most one bit of gnt, done, err set at any time.
REQ-024 eng_start SHALL never assert outside GRANT, and never twice per transaction.

Reset
REQ-025 rst = 1 SHALL immediately (no clock) force state IDLE, gnt = 0, eng_start = 0, done = 0, err = 0, busy = 0, watchdog = 0, last_served = 1 (requester 0 wins first contention).
REQ-026 Reset mid-transaction SHALL abandon the grant with no done/err pulse; first post-reset grant follows REQ-013 and REQ-025.

Verification
REQ-027 Single request: req = 01, engine drops ready 2 cycles after start, raises 10 cycles later -> eng_start one pulse 1 cycle after req, gnt = 01 throughout, done = 01 one cycle, gnt = 00 next cycle.
REQ-028 Contention: req = 11 held continuously after reset -> grant order 0,1,0,1 over four transactions; no back-to-back grant of the same requester while the other requests.
REQ-029 Timeout: req = 10, eng_ready held 1 forever -> WAIT_BUSY holds 199 cycles, err = 10 one cycle, done stays 00, returns to IDLE.
REQ-030 Request drop: req = 01 deasserted in WAIT_DONE -> transaction still completes, done = 01 pulse when eng_ready returns to 1.
REQ-031 Async reset: rst asserted between clock edges during WAIT_DONE -> gnt, busy drop before next rising edge; no done/err; next req = 11 grants requester 0.
REQ-032 Boundary: eng_ready rises in same cycle watchdog reaches TIMEOUT-1 -> err pulse (timeout wins), done stays 00.
